// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx
// Drains a synchronous FIFO one word at a time and sends each word out as an
// asynchronous serial frame: start(0), DATA_WIDTH data bits LSB first,
// optional parity bit, stop(1). Each bit lasts CLKS_PER_BIT clocks.
//
// Ports
//   Clk        system clock, rising edge
//   Rst        synchronous active-high reset
//   EN         allows a new pop when idle; a frame in flight always finishes
//   EMPTY      FIFO empty flag, looked at only in IDLE
//   dataIn     FIFO read data, valid the cycle after RD
//   RD         FIFO read strobe, one cycle per word
//   TXD        registered serial output, idles high
//   BUSY       high in every state except IDLE
//   WORD_DONE  one-cycle pulse in the first IDLE cycle after a stop bit
module fifo_serial_tx #(
  parameter int DATA_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  EN,
  input  logic                  EMPTY,
  input  logic [DATA_WIDTH-1:0] dataIn,
  output logic                  RD,
  output logic                  TXD,
  output logic                  BUSY,
  output logic                  WORD_DONE
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic              PAR_INV   = (PARITY_ODD != 0);
  localparam logic              HAS_PAR   = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    IDLE, POP, LATCH, START, DATA, PARITY, STOP
  } state_t;

  state_t                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  par_q, par_d;
  logic                  txd_q, txd_d;
  logic                  wd_q, wd_d;
  logic                  baud_end;

  assign baud_end  = (baud_q == BAUD_LAST);
  assign RD        = (state_q == POP);
  assign BUSY      = (state_q != IDLE);
  assign TXD       = txd_q;
  assign WORD_DONE = wd_q;

  // TXD is computed from the state being entered, so the registered line
  // changes on the same edge as the state and bit boundaries.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    txd_d   = txd_q;
    wd_d    = 1'b0;
    case (state_q)
      IDLE: begin
        txd_d  = 1'b1;
        baud_d = '0;
        bit_d  = '0;
        if (EN && !EMPTY) state_d = POP;
      end
      POP: state_d = LATCH;
      LATCH: begin
        sh_d    = dataIn;
        par_d   = (^dataIn) ^ PAR_INV;
        baud_d  = '0;
        txd_d   = 1'b0;
        state_d = START;
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          txd_d   = sh_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            if (HAS_PAR) begin
              txd_d   = par_q;
              state_d = PARITY;
            end else begin
              txd_d   = 1'b1;
              state_d = STOP;
            end
          end else begin
            bit_d = bit_q + 1'b1;
            sh_d  = sh_q >> 1;
            txd_d = sh_d[0];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          txd_d   = 1'b1;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          txd_d   = 1'b1;
          wd_d    = 1'b1;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      wd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      wd_q    <= wd_d;
    end
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed bench for fifo_serial_tx: default instance behind a small FIFO
// model, plus odd-parity and no-parity instances sending 0xA5A5A5A5.
module tb_fifo_serial_tx;

  logic        Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Rst;
  logic        en0, en1, en2, empty0, empty1, empty2;
  logic [31:0] din0, din12;
  logic        rd0, txd0, busy0, wd0;
  logic        rd1, txd1, busy1, wd1;
  logic        rd2, txd2, busy2, wd2;

  int total = 0;
  int bad   = 0;

  // FIFO model for instance 0: bench writes mem/wp, model pops on RD
  logic [31:0] mem [0:31];
  int wp = 0;
  int rp = 0;
  int rdcnt = 0;
  int wdcnt = 0;
  assign empty0 = (wp == rp);
  always @(posedge Clk) begin
    if (rd0) begin
      din0  <= mem[rp];
      rp    <= rp + 1;
      rdcnt <= rdcnt + 1;
    end
    if (wd0) wdcnt <= wdcnt + 1;
  end

  fifo_serial_tx dut0 (.Clk(Clk), .Rst(Rst), .EN(en0), .EMPTY(empty0), .dataIn(din0),
    .RD(rd0), .TXD(txd0), .BUSY(busy0), .WORD_DONE(wd0));
  fifo_serial_tx #(.PARITY_ODD(1)) dut1 (.Clk(Clk), .Rst(Rst), .EN(en1), .EMPTY(empty1),
    .dataIn(din12), .RD(rd1), .TXD(txd1), .BUSY(busy1), .WORD_DONE(wd1));
  fifo_serial_tx #(.PARITY_EN(0)) dut2 (.Clk(Clk), .Rst(Rst), .EN(en2), .EMPTY(empty2),
    .dataIn(din12), .RD(rd2), .TXD(txd2), .BUSY(busy2), .WORD_DONE(wd2));

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic txd_of(int s);
    case (s)
      0: return txd0;
      1: return txd1;
      default: return txd2;
    endcase
  endfunction

  task automatic chk(string tag, int obs, int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chkf(string tag, logic [143:0] obs, logic [143:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected line level per clock for a 4-clock/bit frame, cycle 0 = first start clock
  function automatic logic [143:0] exp_frame(logic [31:0] w, bit pen, bit pb);
    logic [143:0] f;
    int nslots;
    f = '0;
    nslots = pen ? 35 : 34;
    for (int c = 0; c < 144; c++) begin
      int sl;
      logic v;
      sl = c / 4;
      if (sl >= nslots)     v = 1'b0;
      else if (sl == 0)     v = 1'b0;
      else if (sl <= 32)    v = w[sl-1];
      else if (pen && sl == 33) v = pb;
      else                  v = 1'b1;
      f[c] = v;
    end
    return f;
  endfunction

  // Bounded wait for the start bit; n = clocks waited
  task automatic wait_start(int s, output int n);
    n = 0;
    while (txd_of(s) !== 1'b0 && n < 300) begin
      tick();
      n++;
    end
    chk("frame_start", int'(txd_of(s)), 0);
  endtask

  task automatic capture(int s, int n, int drop_at, output logic [143:0] f);
    f = '0;
    for (int i = 0; i < n; i++) begin
      f[i] = txd_of(s);
      if (i == drop_at) en0 = 1'b0;
      tick();
    end
  endtask

  logic [143:0] fr;
  int           n, r0, w0;
  bit           ok;
  logic [31:0]  three_w [0:2];
  bit           three_p [0:2];

  initial begin
    three_w[0] = 32'h0; three_w[1] = 32'h1; three_w[2] = 32'h2;
    three_p[0] = 1'b0;  three_p[1] = 1'b1;  three_p[2] = 1'b1;
    Rst = 1'b1; en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
    empty1 = 1'b1; empty2 = 1'b1; din12 = 32'hA5A5A5A5;
    repeat (3) tick();
    chk("reset_state", int'({txd0, busy0, rd0, wd0, txd1, busy1, txd2, busy2}), 8'b1000_1010);
    Rst = 1'b0;
    tick();

    // single word 0x1, latency and full frame
    mem[0] = 32'h1; wp = 1; en0 = 1'b1;
    tick();
    chk("rd_pop", int'(rd0), 1);
    tick();
    chk("latch_cycle", int'({rd0, txd0, busy0}), 3'b011);
    tick();
    capture(0, 140, -1, fr);
    chkf("frame_0x1", fr, exp_frame(32'h1, 1'b1, 1'b1));
    chk("wd_0x1", int'(wd0), 1);
    tick();
    chk("idle_after_0x1", int'({wd0, busy0, txd0}), 3'b001);
    chk("rd_count_1", rdcnt, 1);

    // 0xA5A5A5A5: even, odd, no parity
    mem[1] = 32'hA5A5A5A5; wp = 2;
    wait_start(0, n);
    capture(0, 140, -1, fr);
    chkf("frame_a5_even", fr, exp_frame(32'hA5A5A5A5, 1'b1, 1'b0));
    chk("wd_a5_even", int'(wd0), 1);
    en1 = 1'b1; empty1 = 1'b0;
    tick();
    empty1 = 1'b1;
    wait_start(1, n);
    capture(1, 140, -1, fr);
    chkf("frame_a5_odd", fr, exp_frame(32'hA5A5A5A5, 1'b1, 1'b1));
    chk("wd_a5_odd", int'(wd1), 1);
    en2 = 1'b1; empty2 = 1'b0;
    tick();
    empty2 = 1'b1;
    wait_start(2, n);
    capture(2, 136, -1, fr);
    chkf("frame_a5_nopar", fr, exp_frame(32'hA5A5A5A5, 1'b0, 1'b0));
    chk("wd_a5_nopar_136", int'(wd2), 1);

    // three back-to-back words
    r0 = rdcnt; w0 = wdcnt;
    mem[2] = 32'h0; mem[3] = 32'h1; mem[4] = 32'h2; wp = 5;
    for (int k = 0; k < 3; k++) begin
      wait_start(0, n);
      if (k > 0) chk("gap_3", n, 3);
      capture(0, 140, -1, fr);
      chkf("frame_b2b", fr, exp_frame(three_w[k], 1'b1, three_p[k]));
      chk("wd_b2b", int'(wd0), 1);
    end
    repeat (20) tick();
    chk("drain_idle", int'({busy0, txd0}), 2'b01);
    chk("b2b_rd_count", rdcnt - r0, 3);
    chk("b2b_wd_count", wdcnt - w0, 3);

    // EN low with data pending
    en0 = 1'b0; mem[5] = 32'h12345678; wp = 6; r0 = rdcnt; ok = 1'b1;
    repeat (200) begin
      tick();
      if (rd0 || busy0 || !txd0) ok = 1'b0;
    end
    chk("en_low_hold", int'(ok), 1);
    chk("en_low_no_rd", rdcnt - r0, 0);
    en0 = 1'b1;
    tick();
    chk("rd_after_en", int'(rd0), 1);
    wait_start(0, n);
    capture(0, 140, -1, fr);
    chkf("frame_12345678", fr, exp_frame(32'h12345678, 1'b1, 1'b1));

    // reset 50 cycles into a frame
    mem[6] = 32'hDEADBEEF; mem[7] = 32'h0F0F0F0F; wp = 8;
    wait_start(0, n);
    w0 = wdcnt;
    repeat (50) tick();
    Rst = 1'b1;
    tick();
    chk("reset_mid", int'({txd0, busy0, wd0}), 3'b100);
    Rst = 1'b0;
    tick();
    chk("rd_after_reset", int'(rd0), 1);
    wait_start(0, n);
    capture(0, 140, -1, fr);
    chkf("frame_after_reset", fr, exp_frame(32'h0F0F0F0F, 1'b1, 1'b0));
    chk("no_wd_on_abort", wdcnt - w0, 0);
    chk("wd_after_reset", int'(wd0), 1);

    // EN dropped 10 cycles into a frame
    mem[8] = 32'h3; mem[9] = 32'h4; wp = 10;
    wait_start(0, n);
    capture(0, 140, 10, fr);
    chkf("frame_en_drop", fr, exp_frame(32'h3, 1'b1, 1'b0));
    chk("wd_en_drop", int'(wd0), 1);
    r0 = rdcnt;
    repeat (20) tick();
    chk("en_drop_no_rd", rdcnt - r0, 0);
    chk("en_drop_idle", int'({busy0, txd0}), 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
